// File: rtl/pic_pkg.sv
// Shared definitions for the PIC control-logic slice: sequencer state
// encodings and the MCS-80/85 CALL opcode.
package pic_pkg;

    // Control-logic sequencer states; encodings 5-7 are decoded as READY.
    typedef enum logic [2:0] {
        CTL_READY = 3'd0,
        CTL_ACK1  = 3'd1,
        CTL_ACK2  = 3'd2,
        CTL_ACK3  = 3'd3,
        CTL_POLL  = 3'd4
    } control_state_t;

    // Opcode driven on the first MCS-80/85 acknowledge pulse.
    localparam logic [7:0] CALL_OPCODE = 8'hCD;

endpackage

// File: rtl/pic_ack_data_unit_if.sv
// Bus bundle between the control-logic sequencer and the acknowledge
// data-bus driver. The slave modport is the driver's view.
interface pic_ack_data_unit_if;

    logic       interrupt_acknowledge_n;
    logic       cascade_slave;
    logic       u8086_or_mcs80_config;
    logic [2:0] control_state;
    logic       cascade_output_ack_2_3;
    logic [2:0] interrupt_when_ack1;
    logic [2:0] acknowledge_interrupt;
    logic       call_address_interval_4_or_8_config;
    logic [10:0] interrupt_vector_address;
    logic       read;
    logic       out_control_logic_data;
    logic [7:0] control_logic_data;

    modport master (
        output interrupt_acknowledge_n,
        output cascade_slave,
        output u8086_or_mcs80_config,
        output control_state,
        output cascade_output_ack_2_3,
        output interrupt_when_ack1,
        output acknowledge_interrupt,
        output call_address_interval_4_or_8_config,
        output interrupt_vector_address,
        output read,
        input  out_control_logic_data,
        input  control_logic_data
    );

    modport slave (
        input  interrupt_acknowledge_n,
        input  cascade_slave,
        input  u8086_or_mcs80_config,
        input  control_state,
        input  cascade_output_ack_2_3,
        input  interrupt_when_ack1,
        input  acknowledge_interrupt,
        input  call_address_interval_4_or_8_config,
        input  interrupt_vector_address,
        input  read,
        output out_control_logic_data,
        output control_logic_data
    );

endinterface

// File: rtl/pic_vector_format.sv
// Purely combinational vector-byte formatter. Builds the ACK2 or ACK3 byte
// from the vector address, IR level, processor mode and call interval.
module pic_vector_format
    import pic_pkg::*;
(
    input  logic        mode_8086,
    input  logic        interval_4,
    input  logic        select_ack3,
    input  logic [10:0] vector_address,
    input  logic [2:0]  level,
    output logic [7:0]  vector_byte
);

    // Select the field layout: 8086 type byte, MCS-80 low byte, or MCS-80 high byte.
    always_comb begin
        vector_byte = 8'h00;
        if (mode_8086) begin
            if (!select_ack3) begin
                vector_byte = {vector_address[10:6], level};
            end
        end else if (select_ack3) begin
            vector_byte = vector_address[10:3];
        end else if (interval_4) begin
            vector_byte = {vector_address[2:0], level, 2'b00};
        end else begin
            vector_byte = {vector_address[2:1], level, 3'b000};
        end
    end

endmodule

// File: rtl/pic_ack_data_unit.sv
// Interrupt-acknowledge data-bus driver for the 8259A-compatible PIC.
// Drives the CALL opcode / vector bytes during INTA pulses, registered
// with one cycle of latency.
// Optional: define ACK_POLL_EN to drive the poll word on a POLL read.
module pic_ack_data_unit #(
    parameter logic [7:0] CALL_OPCODE = pic_pkg::CALL_OPCODE
) (
    input  logic                 clock,
    input  logic                 reset,
    pic_ack_data_unit_if.slave   bus
);

    logic       next_out;
    logic [7:0] next_data;
    logic [7:0] vector_byte;
    logic       out_q;
    logic [7:0] data_q;
    logic       is_ack3;
    logic       mode_8086;

    assign mode_8086 = bus.u8086_or_mcs80_config;
    assign is_ack3   = (bus.control_state == pic_pkg::CTL_ACK3);

    pic_vector_format u_vector_format (
        .mode_8086      (mode_8086),
        .interval_4     (bus.call_address_interval_4_or_8_config),
        .select_ack3    (is_ack3),
        .vector_address (bus.interrupt_vector_address),
        .level          (bus.interrupt_when_ack1),
        .vector_byte    (vector_byte)
    );

    // Decode the next bus byte; INTA has priority over a poll read.
    always_comb begin
        next_out  = 1'b0;
        next_data = 8'h00;
        if (!bus.interrupt_acknowledge_n) begin
            case (bus.control_state)
                pic_pkg::CTL_ACK2: begin
                    if (bus.cascade_output_ack_2_3) begin
                        next_out  = 1'b1;
                        next_data = vector_byte;
                    end
                end
                pic_pkg::CTL_ACK3: begin
                    if (bus.cascade_output_ack_2_3 && !mode_8086) begin
                        next_out  = 1'b1;
                        next_data = vector_byte;
                    end
                end
                pic_pkg::CTL_POLL: begin
                    next_out  = 1'b0;
                end
                default: begin
                    if (!bus.cascade_slave && !mode_8086) begin
                        next_out  = 1'b1;
                        next_data = CALL_OPCODE;
                    end
                end
            endcase
        end
`ifdef ACK_POLL_EN
        else if (bus.read && (bus.control_state == pic_pkg::CTL_POLL)) begin
            next_out  = 1'b1;
            next_data = {1'b1, 4'b0000, bus.acknowledge_interrupt};
        end
`endif
    end

    // Output register; reset clears the bus drive immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            out_q  <= next_out;
            data_q <= next_data;
        end
    end

    assign bus.out_control_logic_data = out_q;
    assign bus.control_logic_data     = data_q;

endmodule

// File: tb/tb_pic_ack_data_unit.sv
// Scoreboard bench for pic_ack_data_unit: each stimulus pushes its expected
// registered response; a monitor pops and compares one cycle later.
module tb_pic_ack_data_unit;

    typedef struct {
        string      name;
        logic       out;
        logic [7:0] data;
    } expect_t;

    logic clock;
    logic reset;
    int   checkCount;
    int   errorCount;
    expect_t expectQ[$];

    pic_ack_data_unit_if bus ();

    pic_ack_data_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic expOut, input logic [7:0] expData);
        checkCount++;
        if (bus.out_control_logic_data !== expOut || bus.control_logic_data !== expData) begin
            errorCount++;
            $display("[TB] FAIL %s: got out=%0b data=%02h, expected out=%0b data=%02h",
                     name, bus.out_control_logic_data, bus.control_logic_data, expOut, expData);
        end
    endtask

    // Monitor: just after each rising edge, compare the registered output to the oldest expectation.
    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expectQ.size() > 0) begin
                e = expectQ.pop_front();
                checkOutput(e.name, e.out, e.data);
            end
        end
    end

    task automatic applyStimulus(
        input string       name,
        input logic        rst,
        input logic        intaN,
        input logic        slave,
        input logic        m8086,
        input logic [2:0]  state,
        input logic        ack23,
        input logic [2:0]  lvl,
        input logic [2:0]  ackInt,
        input logic        int4,
        input logic [10:0] addr,
        input logic        rd,
        input logic        expOut,
        input logic [7:0]  expData
    );
        expect_t e;
        @(negedge clock);
        reset                                   = rst;
        bus.interrupt_acknowledge_n             = intaN;
        bus.cascade_slave                       = slave;
        bus.u8086_or_mcs80_config               = m8086;
        bus.control_state                       = state;
        bus.cascade_output_ack_2_3              = ack23;
        bus.interrupt_when_ack1                 = lvl;
        bus.acknowledge_interrupt               = ackInt;
        bus.call_address_interval_4_or_8_config = int4;
        bus.interrupt_vector_address            = addr;
        bus.read                                = rd;
        e.name = name;
        e.out  = expOut;
        e.data = expData;
        expectQ.push_back(e);
        @(posedge clock);
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (expectQ.size() > 0 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (expectQ.size() > 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expectQ.size());
        end
    endtask

    // Directed vectors with hand-computed responses.
    initial begin
        logic       pollOut;
        logic [7:0] pollData;
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        bus.interrupt_acknowledge_n             = 1'b1;
        bus.cascade_slave                       = 1'b0;
        bus.u8086_or_mcs80_config               = 1'b0;
        bus.control_state                       = 3'd0;
        bus.cascade_output_ack_2_3              = 1'b0;
        bus.interrupt_when_ack1                 = 3'd0;
        bus.acknowledge_interrupt               = 3'd0;
        bus.call_address_interval_4_or_8_config = 1'b0;
        bus.interrupt_vector_address            = 11'h000;
        bus.read                                = 1'b0;
`ifdef ACK_POLL_EN
        pollOut  = 1'b1;
        pollData = 8'h85;
`else
        pollOut  = 1'b0;
        pollData = 8'h00;
`endif

        //             name            rst inta slv 86 st ack lvl ai i4 addr    rd  out data
        applyStimulus("reset_hold",    1,  0,   0,  0, 1, 0,  0,  0, 0, 11'h000, 0, 0, 8'h00);
        applyStimulus("reset_release", 0,  0,   0,  0, 1, 0,  0,  0, 0, 11'h000, 0, 1, 8'hCD);
        applyStimulus("ack1_slave",    0,  0,   1,  0, 1, 0,  0,  0, 0, 11'h000, 0, 0, 8'h00);
        applyStimulus("ack2_int4",     0,  0,   0,  0, 2, 1,  3,  0, 1, 11'h002, 0, 1, 8'h4C);
        applyStimulus("ack2_int8",     0,  0,   0,  0, 2, 1,  3,  0, 0, 11'h002, 0, 1, 8'h58);
        applyStimulus("ack2_no_own",   0,  0,   0,  0, 2, 0,  3,  0, 0, 11'h002, 0, 0, 8'h00);
        applyStimulus("ack3_mcs80",    0,  0,   0,  0, 3, 1,  3,  0, 0, 11'h540, 0, 1, 8'hA8);
        applyStimulus("ack2_8086",     0,  0,   0,  1, 2, 1,  2,  0, 0, 11'h540, 0, 1, 8'hAA);
        applyStimulus("ack3_8086",     0,  0,   0,  1, 3, 1,  2,  0, 0, 11'h540, 0, 0, 8'h00);
        applyStimulus("ready_8086",    0,  0,   0,  1, 0, 0,  0,  0, 0, 11'h540, 0, 0, 8'h00);
        applyStimulus("state7_call",   0,  0,   0,  0, 7, 0,  0,  0, 0, 11'h540, 0, 1, 8'hCD);
        applyStimulus("poll_inta",     0,  0,   0,  0, 4, 1,  0,  5, 0, 11'h540, 0, 0, 8'h00);
        applyStimulus("poll_read",     0,  1,   0,  0, 4, 0,  0,  5, 0, 11'h540, 1, pollOut, pollData);
        applyStimulus("inta_over_rd",  0,  0,   0,  0, 1, 0,  0,  5, 0, 11'h540, 1, 1, 8'hCD);
        applyStimulus("inta_poll_rd",  0,  0,   0,  0, 4, 0,  0,  5, 0, 11'h540, 1, 0, 8'h00);
        applyStimulus("idle_ack2",     0,  1,   0,  0, 2, 1,  3,  0, 0, 11'h540, 0, 0, 8'h00);
        applyStimulus("read_ack1",     0,  1,   0,  0, 1, 0,  0,  5, 0, 11'h540, 1, 0, 8'h00);
        applyStimulus("pre_reset",     0,  0,   0,  0, 1, 0,  0,  0, 0, 11'h540, 0, 1, 8'hCD);
        waitDrain();

        // Reset mid-acknowledge must clear the outputs without waiting for an edge.
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 8'h00);
        applyStimulus("post_reset",    0,  0,   0,  0, 1, 0,  0,  0, 0, 11'h540, 0, 1, 8'hCD);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pic_ack_data_unit.md
Name: pic_ack_data_unit

Overview:
- Interrupt-acknowledge data-bus driver for the 8259A-compatible PIC control-logic block.
- Forms the byte placed on the data bus during INTA pulses:
  - MCS-80/85 mode: CALL opcode, then vector low byte, then vector high byte.
  - 8086 mode: vector byte only.
- Also forms the poll word during a poll read.
- Sits between the control-logic state machine (source of control_state) and the data-bus output mux.

Parameters:
- CALL_OPCODE, 8'hCD, byte driven on the first MCS-80 acknowledge.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- interrupt_acknowledge_n  in  1  INTA#, active low
- cascade_slave  in  1  1 = this device is a cascaded slave
- u8086_or_mcs80_config  in  1  1 = 8086 mode, 0 = MCS-80/85 mode
- control_state  in  3  sequencer state: READY=0, ACK1=1, ACK2=2, ACK3=3, POLL=4; values 5-7 are treated as READY
- cascade_output_ack_2_3  in  1  1 = this device owns the ACK2/ACK3 bytes
- interrupt_when_ack1  in  3  IR level latched at ACK1
- acknowledge_interrupt  in  3  current highest-priority pending IR level
- call_address_interval_4_or_8_config  in  1  MCS-80 vector interval: 1 = interval 4, 0 = interval 8
- interrupt_vector_address  in  11  MCS-80: bits [10:3] = A15..A8, bits [2:0] = A7..A5. 8086: bits [10:6] = T7..T3
- read  in  1  RD# asserted (active high here)
- out_control_logic_data  out  1  1 = drive control_logic_data onto the bus
- control_logic_data  out  8  byte to drive

Behaviour:
- Clocking:
  - Combinational next-value decode, registered on the rising edge of clock; latency is 1 cycle.
  - Reset forces out_control_logic_data=0 and control_logic_data=8'h00 immediately.
- Default for every case not listed below: out=0, data=8'h00.
- In the cases below, `lvl` means interrupt_when_ack1.
- When interrupt_acknowledge_n=0, decode by control_state:
  - READY or ACK1:
    - Not slave and MCS-80 mode: out=1, data=CALL_OPCODE.
    - Otherwise: out=0.
  - ACK2, with cascade_output_ack_2_3=1:
    - 8086: out=1, data={addr[10:6], lvl}.
    - MCS-80, interval 4: out=1, data={addr[2:0], lvl, 2'b00}.
    - MCS-80, interval 8: out=1, data={addr[2:1], lvl, 3'b000}.
  - ACK2, with cascade_output_ack_2_3=0: out=0. This covers a master whose selected IR input is a cascaded slave.
  - ACK3, with cascade_output_ack_2_3=1:
    - MCS-80: out=1, data=addr[10:3].
    - 8086: out=0, because 8086 uses only two pulses.
  - POLL: out=0.
- INTA takes priority over read when both are active.
- When interrupt_acknowledge_n=1, read=1 and control_state=POLL: behaviour is set by ACK_POLL_EN (see Optional Feature).
- When interrupt_acknowledge_n=1 and not in that poll case: out=0. Register reads are driven by another block.
- Reset asserted mid-acknowledge clears the outputs at once. After reset deasserts, the next clock edge decodes the current inputs.
- All field slicing is fixed-width; there is no arithmetic.

Optional Feature:
- Macro: ACK_POLL_EN.
- Defined: the poll read (interrupt_acknowledge_n=1, read=1, control_state=POLL) gives out=1, data={1'b1, 4'b0000, acknowledge_interrupt}.
- Undefined: the POLL read case gives out=0, data=8'h00, and the acknowledge_interrupt input is unused.

Decomposition:
- Shared package pic_pkg holds:
  - the control_state encodings (CTL_READY, ACK1, ACK2, ACK3, POLL), shared with the control-logic sequencer;
  - the CALL_OPCODE constant.
- One natural sub-module, pic_vector_format: purely combinational. It takes the mode, interval, address, level and a byte select (ACK2 or ACK3) and returns the vector byte. The top block adds the selection/enable logic and the output register.

Test Plan:
- Reset asserted with INTA active in ACK1 -> out=0, data=00 while reset is high. One cycle after release: out=1, data=CD.
- MCS-80 mode, master, INTA=0, ACK1 -> out=1, data=CD. Same with cascade_slave=1 -> out=0, data=00.
- MCS-80 ACK2, cascade_output_ack_2_3=1, lvl=3, addr[2:0]=3'b010:
  - interval 4 -> data=4C;
  - interval 8 -> data=58;
  - with cascade_output_ack_2_3=0 -> out=0.
- Address 11'h540 (A15..A8=0xA8):
  - MCS-80 ACK3 -> data=A8, out=1;
  - 8086 ACK2 with lvl=2 -> data=AA;
  - 8086 ACK3 -> out=0.
- INTA=1, read=1, POLL, acknowledge_interrupt=5:
  - with ACK_POLL_EN -> out=1, data=85;
  - without it -> out=0, data=00.
- INTA=1, read=0, any state -> out=0, data=00.
